// File: rtl/muldiv_pkg.sv
// muldiv_pkg: op codes, FSM state encoding and HI/LO write-enable constant
// shared by the multiply/divide sequencer and its divider core.
`default_nettype none

package muldiv_pkg;

  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;
  localparam logic [1:0] OP_DIVU  = 2'b11;

  localparam logic [1:0] HILO_WE_BOTH = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2,
    S_DONE = 2'd3
  } state_e;

endpackage

`default_nettype wire

// File: rtl/muldiv_sched_div_iter.sv
// div_iter: unsigned restoring divider, one quotient bit per step (MSB first).
// Exposes the next-step quotient/remainder so the caller can capture the final result on the last step.
`default_nettype none

module div_iter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_i,
  input  logic             step_i,
  input  logic [WIDTH-1:0] dividend_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic             last_o,
  output logic [WIDTH-1:0] quo_nxt_o,
  output logic [WIDTH-1:0] rem_nxt_o
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH:0]   shift_w;
  logic [WIDTH:0]   diff_w;
  logic [WIDTH-1:0] quo_step;
  logic [WIDTH-1:0] rem_step;

  always_comb begin
    shift_w = {rem_q, quo_q[WIDTH-1]};
    diff_w  = shift_w - {1'b0, dvs_q};
    // Non-negative trial difference: keep it and shift in a 1.
    if (!diff_w[WIDTH]) begin
      rem_step = diff_w[WIDTH-1:0];
      quo_step = {quo_q[WIDTH-2:0], 1'b1};
    end else begin
      rem_step = shift_w[WIDTH-1:0];
      quo_step = {quo_q[WIDTH-2:0], 1'b0};
    end

    quo_d = quo_q;
    rem_d = rem_q;
    dvs_d = dvs_q;
    cnt_d = cnt_q;
    if (load_i) begin
      quo_d = dividend_i;
      rem_d = '0;
      dvs_d = divisor_i;
      cnt_d = '0;
    end else if (step_i) begin
      quo_d = quo_step;
      rem_d = rem_step;
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      quo_q <= '0;
      rem_q <= '0;
      dvs_q <= '0;
      cnt_q <= '0;
    end else begin
      quo_q <= quo_d;
      rem_q <= rem_d;
      dvs_q <= dvs_d;
      cnt_q <= cnt_d;
    end
  end

  assign last_o    = (cnt_q == CNT_LAST);
  assign quo_nxt_o = quo_step;
  assign rem_nxt_o = rem_step;

endmodule

`default_nettype wire

// File: rtl/muldiv_sched.sv
// muldiv_sched: MULT/MULTU/DIV/DIVU sequencer beside the execute stage; stalls the
// pipeline while busy and writes HI/LO through a one-cycle strobe on completion.
`default_nettype none

module muldiv_sched
  import muldiv_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int MUL_LAT = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             startE,
  input  logic [1:0]       opE,
  input  logic [WIDTH-1:0] srcaE,
  input  logic [WIDTH-1:0] srcbE,
  input  logic             cancel,
  output logic             stall_md,
  output logic             busy,
  output logic [1:0]       hilo_we,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  localparam int MCNT_W = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;
  localparam logic [MCNT_W-1:0] MCNT_LAST = MCNT_W'(MUL_LAT - 1);

  state_e              state_q, state_d;
  logic [MCNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]    hi_q, lo_q;
  logic [WIDTH-1:0]    res_hi_d, res_lo_d;
  logic                neg_quo_q, neg_rem_q, div0_q;
  logic [WIDTH-1:0]    a_raw_q;
  logic [2*WIDTH-1:0]  mul_pipe_q [MUL_LAT];

  logic                start;
  logic                is_sdiv;
  logic                mul_signed;
  logic [WIDTH-1:0]    a_mag, b_mag;
  logic [2*WIDTH-1:0]  ext_a, ext_b, product;
  logic                div_last;
  logic [WIDTH-1:0]    quo_nxt, rem_nxt;

  assign start      = (state_q == S_IDLE) && startE && !cancel;
  assign is_sdiv    = (opE == OP_DIV);
  assign mul_signed = (opE == OP_MULT);

  assign a_mag = (is_sdiv && srcaE[WIDTH-1]) ? -srcaE : srcaE;
  assign b_mag = (is_sdiv && srcbE[WIDTH-1]) ? -srcbE : srcbE;

  // Extending both operands to 2*WIDTH makes one multiplier serve signed and unsigned.
  assign ext_a   = {{WIDTH{mul_signed & srcaE[WIDTH-1]}}, srcaE};
  assign ext_b   = {{WIDTH{mul_signed & srcbE[WIDTH-1]}}, srcbE};
  assign product = ext_a * ext_b;

  div_iter #(
    .WIDTH (WIDTH)
  ) u_div_iter (
    .clk        (clk),
    .rst_n      (rst),
    .load_i     (start && opE[1]),
    .step_i     (state_q == S_DIV),
    .dividend_i (a_mag),
    .divisor_i  (b_mag),
    .last_o     (div_last),
    .quo_nxt_o  (quo_nxt),
    .rem_nxt_o  (rem_nxt)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = opE[1] ? S_DIV : S_MUL;
          cnt_d   = '0;
        end
      end
      S_MUL: begin
        if (cancel)                  state_d = S_IDLE;
        else if (cnt_q == MCNT_LAST) state_d = S_DONE;
        else                         cnt_d   = cnt_q + 1'b1;
      end
      S_DIV: begin
        if (cancel)        state_d = S_IDLE;
        else if (div_last) state_d = S_DONE;
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    res_hi_d = hi_q;
    res_lo_d = lo_q;
    if (state_q == S_MUL) begin
      {res_hi_d, res_lo_d} = mul_pipe_q[MUL_LAT-1];
    end else if (div0_q) begin
      res_hi_d = a_raw_q;
      res_lo_d = '1;
    end else begin
      res_lo_d = neg_quo_q ? -quo_nxt : quo_nxt;
      res_hi_d = neg_rem_q ? -rem_nxt : rem_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      neg_quo_q <= 1'b0;
      neg_rem_q <= 1'b0;
      div0_q    <= 1'b0;
      a_raw_q   <= '0;
      for (int i = 0; i < MUL_LAT; i++) mul_pipe_q[i] <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (start) begin
        neg_quo_q     <= is_sdiv && (srcaE[WIDTH-1] ^ srcbE[WIDTH-1]);
        neg_rem_q     <= is_sdiv && srcaE[WIDTH-1];
        div0_q        <= (srcbE == '0);
        a_raw_q       <= srcaE;
        mul_pipe_q[0] <= product;
      end
      for (int i = 1; i < MUL_LAT; i++) mul_pipe_q[i] <= mul_pipe_q[i-1];
      // Results land only on the edge entering DONE, so a cancel never disturbs HI/LO.
      if (state_d == S_DONE) begin
        hi_q <= res_hi_d;
        lo_q <= res_lo_d;
      end
    end
  end

  assign stall_md = start || (state_q == S_MUL) || (state_q == S_DIV);
  assign busy     = (state_q != S_IDLE);
  assign hilo_we  = ((state_q == S_DONE) && !cancel) ? HILO_WE_BOTH : 2'b00;
  assign hi_o     = hi_q;
  assign lo_o     = lo_q;

endmodule

`default_nettype wire
